error_frame_tx: RTL and testbench

- Transmit side of CAN error signalling: once the error detector raises ERROR, this block drives the error frame onto TX.
- Frame content: error flag, then echo wait, then error delimiter, then intermission.
- It also starts overload frames when the intermission is violated, and reports bus faults seen while transmitting.
- It sits between the error detection block and the TX bit mux, clocked at the bit sample point (one state step per bit time).

---
 rtl/error_frame_tx.sv | 157 +++++++++++++++
 tb/tb_error_frame_tx.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/error_frame_tx.sv
// CAN error-frame transmitter: drives error/overload flag, echo wait, delimiter
// and intermission onto TX, one state step per bit time on the sample-point clock.
module error_frame_tx #(
  parameter int unsigned FLAG_LEN  = 6,
  parameter int unsigned DELIM_LEN = 8,
  parameter int unsigned IFS_LEN   = 3,
  parameter int unsigned WAIT_MAX  = 14
) (
  input  logic SP,
  input  logic reset,
  input  logic ERROR,
  input  logic RX,
  input  logic err_passive,
  output logic TX,
  output logic busy,
  output logic flag_active,
  output logic done,
  output logic ovl_start,
  output logic dom_overrun,
  output logic delim_err
);

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned CNT_MAX = 15;

  // Counts must fit the 4-bit bit counter; delimiter needs room for the WAIT bit.
  if (FLAG_LEN < 1 || FLAG_LEN > CNT_MAX || DELIM_LEN < 2 || DELIM_LEN > CNT_MAX ||
      IFS_LEN < 1 || IFS_LEN > CNT_MAX || WAIT_MAX < 1 || WAIT_MAX > CNT_MAX) begin : g_bad_params
    $error("error_frame_tx: parameter out of range 1..15 (DELIM_LEN 2..15)");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FLAG  = 3'd1,
    WAIT  = 3'd2,
    DELIM = 3'd3,
    IFS   = 3'd4
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc, flag_run;
  logic             mode, mode_n;
  logic             prev_rx;
  logic             tx_n, done_n, ovl_n, overrun_n, delim_err_n;

  // Next-state, counter and pulse decode.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    mode_n      = mode;
    done_n      = 1'b0;
    ovl_n       = 1'b0;
    overrun_n   = 1'b0;
    delim_err_n = 1'b0;
    cnt_inc     = cnt + CNT_W'(1);
    // Passive flag: run length of equal RX samples; the first sample opens a run.
    flag_run    = (cnt == '0 || RX != prev_rx) ? CNT_W'(1) : cnt_inc;

    case (state)
      IDLE: begin
        if (ERROR) begin
          state_n = FLAG;
          cnt_n   = '0;
          mode_n  = err_passive;
        end
      end

      FLAG: begin
        if ((mode ? flag_run : cnt_inc) == CNT_W'(FLAG_LEN)) begin
          state_n = WAIT;
          cnt_n   = '0;
        end else begin
          cnt_n = mode ? flag_run : cnt_inc;
        end
      end

      WAIT: begin
        if (RX) begin
          // This recessive bit is already delimiter bit 1.
          state_n = DELIM;
          cnt_n   = CNT_W'(1);
        end else if (cnt_inc == CNT_W'(WAIT_MAX)) begin
          overrun_n = 1'b1;
          cnt_n     = '0;
        end else begin
          cnt_n = cnt_inc;
        end
      end

      DELIM: begin
        if (!RX) begin
          delim_err_n = 1'b1;
          state_n     = FLAG;
          cnt_n       = '0;
        end else if (cnt_inc == CNT_W'(DELIM_LEN)) begin
          state_n = IFS;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_inc;
        end
      end

      IFS: begin
        // Dominant on the last IFS bit is a start of frame, not an overload.
        if (cnt_inc == CNT_W'(IFS_LEN)) begin
          done_n  = 1'b1;
          state_n = IDLE;
          cnt_n   = '0;
        end else if (!RX) begin
          ovl_n   = 1'b1;
          state_n = FLAG;
          mode_n  = 1'b0;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_inc;
        end
      end

      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    tx_n = !(state_n == FLAG && !mode_n);
  end

  // State and registered outputs.
  always_ff @(posedge SP) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      mode        <= 1'b0;
      prev_rx     <= 1'b1;
      TX          <= 1'b1;
      busy        <= 1'b0;
      flag_active <= 1'b0;
      done        <= 1'b0;
      ovl_start   <= 1'b0;
      dom_overrun <= 1'b0;
      delim_err   <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      mode        <= mode_n;
      prev_rx     <= RX;
      TX          <= tx_n;
      busy        <= (state_n != IDLE);
      flag_active <= (state_n == FLAG);
      done        <= done_n;
      ovl_start   <= ovl_n;
      dom_overrun <= overrun_n;
      delim_err   <= delim_err_n;
    end
  end

endmodule

// File: tb/tb_error_frame_tx.sv
// Directed bench for error_frame_tx; each frame is checked cycle by cycle against
// hand-derived output vectors {TX,busy,flag_active,done,ovl_start,dom_overrun,delim_err}.
module tb_error_frame_tx;

  logic SP = 1'b0;
  logic reset, ERROR, RX, err_passive;
  logic TX, busy, flag_active, done, ovl_start, dom_overrun, delim_err;

  int n_checks = 0;
  int n_errors = 0;

  error_frame_tx dut (
    .SP          (SP),
    .reset       (reset),
    .ERROR       (ERROR),
    .RX          (RX),
    .err_passive (err_passive),
    .TX          (TX),
    .busy        (busy),
    .flag_active (flag_active),
    .done        (done),
    .ovl_start   (ovl_start),
    .dom_overrun (dom_overrun),
    .delim_err   (delim_err)
  );

  always #5 SP = ~SP;

  logic [6:0] outs;
  assign outs = {TX, busy, flag_active, done, ovl_start, dom_overrun, delim_err};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (TX,busy,flag,done,ovl,dov,derr)", tag, got[6:0], exp[6:0]);
    end
  endtask

  function automatic logic [6:0] v(input logic tx, input logic bz, input logic fa, input logic dn,
                                   input logic ov, input logic dv, input logic de);
    return {tx, bz, fa, dn, ov, dv, de};
  endfunction

  // Apply RX for one bit time and sample 1 time unit after the edge.
  task automatic step(input logic rx);
    RX = rx;
    @(posedge SP);
    #1;
  endtask

  localparam logic [6:0] IDLE_V = 7'b1000000;

  initial begin
    reset = 1'b1; ERROR = 1'b0; RX = 1'b1; err_passive = 1'b0;
    step(1'b1);
    check("reset", 32'(outs), 32'(IDLE_V));
    reset = 1'b0;
    step(1'b1);
    check("idle", 32'(outs), 32'(IDLE_V));

    // Active error, clean bus: 6 dominant, 11 recessive, done 17 cycles after ERROR.
    for (int e = 0; e <= 18; e++) begin
      ERROR = (e == 0);
      step(1'b1);
      check($sformatf("active e%0d", e), 32'(outs),
            32'(v(!(e <= 5), e <= 16, e <= 5, e == 17, 1'b0, 1'b0, 1'b0)));
    end

    // Passive flag: equal-bit run restarts at the first 1, needs six 1s.
    err_passive = 1'b1;
    for (int e = 0; e <= 19; e++) begin
      ERROR = (e == 0);
      step(e != 1);
      check($sformatf("passive e%0d", e), 32'(outs),
            32'(v(1'b1, e <= 17, e <= 6, e == 18, 1'b0, 1'b0, 1'b0)));
    end

    // Echo superposition: 20 dominant bits in WAIT, overrun after 14.
    err_passive = 1'b0;
    for (int e = 0; e <= 38; e++) begin
      ERROR = (e == 0);
      step(!(e >= 1 && e <= 26));
      check($sformatf("echo e%0d", e), 32'(outs),
            32'(v(!(e <= 5), e <= 36, e <= 5, e == 37, 1'b0, e == 20, 1'b0)));
    end

    // Dominant on delimiter bit 4 re-signals with a fresh 6-bit flag.
    for (int e = 0; e <= 28; e++) begin
      logic fa;
      ERROR = (e == 0);
      fa = (e <= 5) || (e >= 10 && e <= 15);
      step(e != 10);
      check($sformatf("delim e%0d", e), 32'(outs),
            32'(v(!fa, e <= 26, fa, e == 27, 1'b0, 1'b0, e == 10)));
    end

    // Overload on IFS bit 2: dominant flag even though err_passive=1.
    err_passive = 1'b1;
    for (int e = 0; e <= 34; e++) begin
      logic ovf;
      ERROR = (e == 0);
      ovf = (e >= 16 && e <= 21);
      step(e != 16);
      check($sformatf("ovl e%0d", e), 32'(outs),
            32'(v(!ovf, e <= 32, (e <= 5) || ovf, e == 33, e == 16, 1'b0, 1'b0)));
    end

    // Dominant on IFS bit 3 is SOF: done, IDLE; ERROR on that edge is ignored.
    err_passive = 1'b0;
    for (int e = 0; e <= 18; e++) begin
      logic fa;
      ERROR = (e == 0) || (e >= 17);
      fa = (e <= 5) || (e >= 18);
      step(e != 17);
      check($sformatf("sof e%0d", e), 32'(outs),
            32'(v(!fa, (e <= 16) || (e >= 18), fa, e == 17, 1'b0, 1'b0, 1'b0)));
    end
    ERROR = 1'b0;
    reset = 1'b1;
    step(1'b1);
    check("reset flag", 32'(outs), 32'(IDLE_V));
    reset = 1'b0;

    // Reset on flag bit 3 aborts the frame with no done pulse.
    for (int e = 0; e <= 20; e++) begin
      ERROR = (e == 0);
      reset = (e == 3);
      step(1'b1);
      check($sformatf("rst e%0d", e), 32'(outs),
            32'((e <= 2) ? v(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0) : IDLE_V));
    end
    reset = 1'b0;

    // ERROR held high while busy has no effect on the frame.
    for (int e = 0; e <= 19; e++) begin
      ERROR = (e <= 16);
      step(1'b1);
      check($sformatf("hold e%0d", e), 32'(outs),
            32'(v(!(e <= 5), e <= 16, e <= 5, e == 17, 1'b0, 1'b0, 1'b0)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
